// File: rtl/enoc_network_interface.sv
// ENoC endpoint network interface: core <-> router port 0.
// One FIFO per direction, packet counters and a sticky misroute flag.
module enoc_network_interface #(
  parameter int NODES    = 16,
  parameter int LOC      = 0,
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4,
  parameter int PKT_W    = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [PKT_W-1:0] i_core_data,
  input  logic             i_core_val,
  output logic             o_core_en,
  output logic [PKT_W-1:0] o_net_data,
  output logic             o_net_val,
  input  logic             i_net_en,
  input  logic [PKT_W-1:0] i_net_data,
  input  logic             i_net_val,
  output logic             o_net_en,
  output logic [PKT_W-1:0] o_core_data,
  output logic             o_core_val,
  input  logic             i_core_en,
  output logic [31:0]      o_tx_count,
  output logic [31:0]      o_rx_count,
  output logic             o_dest_err
);

  localparam int DW  = $clog2(NODES);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);

  localparam logic [TAW:0] TX_N = (TAW+1)'(TX_DEPTH);
  localparam logic [RAW:0] RX_N = (RAW+1)'(RX_DEPTH);
  localparam logic [RAW:0] RX_SLACK = (RAW+1)'(RX_DEPTH - 2);
  localparam logic [DW-1:0] LOC_A = DW'(LOC);

  logic [TAW:0]       tx_wr_q, tx_wr_d;
  logic [TAW:0]       tx_rd_q, tx_rd_d;
  logic [RAW:0]       rx_wr_q, rx_wr_d;
  logic [RAW:0]       rx_rd_q, rx_rd_d;
  logic [31:0]        tx_count_q, tx_count_d;
  logic [31:0]        rx_count_q, rx_count_d;
  logic               dest_err_q, dest_err_d;
  logic [PKT_W-1:0]   tx_mem_q [TX_DEPTH];
  logic [PKT_W-1:0]   rx_mem_q [RX_DEPTH];

  logic [TAW:0] tx_cnt;
  logic [RAW:0] rx_cnt;
  logic         tx_full, tx_empty, tx_push, tx_pop;
  logic         rx_full, rx_empty, rx_push, rx_pop;

  always_comb begin
    tx_cnt   = tx_wr_q - tx_rd_q;
    rx_cnt   = rx_wr_q - rx_rd_q;
    tx_full  = (tx_cnt == TX_N);
    tx_empty = (tx_cnt == '0);
    rx_full  = (rx_cnt == RX_N);
    rx_empty = (rx_cnt == '0);
    tx_push  = i_core_val & ~tx_full;
    tx_pop   = ~tx_empty & i_net_en;
    // A committed router grant is always taken unless it would overflow.
    rx_push  = i_net_val & ~rx_full;
    rx_pop   = ~rx_empty & i_core_en;
  end

  always_comb begin
    tx_wr_d    = tx_wr_q + (TAW+1)'(tx_push);
    tx_rd_d    = tx_rd_q + (TAW+1)'(tx_pop);
    rx_wr_d    = rx_wr_q + (RAW+1)'(rx_push);
    rx_rd_d    = rx_rd_q + (RAW+1)'(rx_pop);
    tx_count_d = tx_count_q + 32'(tx_pop);
    rx_count_d = rx_count_q + 32'(rx_pop);
    dest_err_d = dest_err_q;
    if (rx_push && (i_net_data[DW-1:0] != LOC_A))
      dest_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_wr_q    <= '0;
      tx_rd_q    <= '0;
      rx_wr_q    <= '0;
      rx_rd_q    <= '0;
      tx_count_q <= '0;
      rx_count_q <= '0;
      dest_err_q <= 1'b0;
    end else begin
      tx_wr_q    <= tx_wr_d;
      tx_rd_q    <= tx_rd_d;
      rx_wr_q    <= rx_wr_d;
      rx_rd_q    <= rx_rd_d;
      tx_count_q <= tx_count_d;
      rx_count_q <= rx_count_d;
      dest_err_q <= dest_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push)
      tx_mem_q[tx_wr_q[TAW-1:0]] <= i_core_data;
    if (rx_push)
      rx_mem_q[rx_wr_q[RAW-1:0]] <= i_net_data;
  end

  // One free slot of slack covers a grant made on last cycle's enable.
  assign o_core_en   = ~tx_full;
  assign o_net_val   = ~tx_empty;
  assign o_net_en    = (rx_cnt <= RX_SLACK);
  assign o_core_val  = ~rx_empty;
  assign o_net_data  = tx_empty ? '0 : tx_mem_q[tx_rd_q[TAW-1:0]];
  assign o_core_data = rx_empty ? '0 : rx_mem_q[rx_rd_q[RAW-1:0]];
  assign o_tx_count  = tx_count_q;
  assign o_rx_count  = rx_count_q;
  assign o_dest_err  = dest_err_q;

  rx_overflow_a: assert property (
    @(posedge clk) disable iff (!reset_n) !(i_net_val && rx_full));

endmodule

// File: tb/tb_enoc_network_interface.sv
// Randomized scoreboard bench for enoc_network_interface.
// Queue-level reference model, negedge monitor, directed phases.
module tb_enoc_network_interface;

  localparam int TXD = 4;
  localparam int RXD = 4;
  localparam int LOC = 0;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] i_core_data = '0;
  logic        i_core_val = 1'b0;
  logic        o_core_en;
  logic [31:0] o_net_data;
  logic        o_net_val;
  logic        i_net_en = 1'b0;
  logic [31:0] i_net_data = '0;
  logic        i_net_val = 1'b0;
  logic        o_net_en;
  logic [31:0] o_core_data;
  logic        o_core_val;
  logic        i_core_en = 1'b0;
  logic [31:0] o_tx_count;
  logic [31:0] o_rx_count;
  logic        o_dest_err;

  enoc_network_interface #(
    .NODES(16), .LOC(LOC), .TX_DEPTH(TXD), .RX_DEPTH(RXD), .PKT_W(32)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .i_core_data(i_core_data), .i_core_val(i_core_val),
    .o_core_en(o_core_en),
    .o_net_data(o_net_data), .o_net_val(o_net_val),
    .i_net_en(i_net_en),
    .i_net_data(i_net_data), .i_net_val(i_net_val),
    .o_net_en(o_net_en),
    .o_core_data(o_core_data), .o_core_val(o_core_val),
    .i_core_en(i_core_en),
    .o_tx_count(o_tx_count), .o_rx_count(o_rx_count),
    .o_dest_err(o_dest_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  // Reference model: two packet queues, counters, sticky error bit.
  logic [31:0] txq[$];
  logic [31:0] rxq[$];
  logic [31:0] m_tx = '0;
  logic [31:0] m_rx = '0;
  logic        m_err = 1'b0;
  bit          t_push, t_pop, r_push, r_pop;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      txq.delete();
      rxq.delete();
      m_tx = '0;
      m_rx = '0;
      m_err = 1'b0;
    end else begin
      t_pop  = (txq.size() > 0) && i_net_en;
      t_push = i_core_val && (txq.size() < TXD);
      r_pop  = (rxq.size() > 0) && i_core_en;
      r_push = i_net_val && (rxq.size() < RXD);
      if (t_pop) begin
        void'(txq.pop_front());
        m_tx++;
      end
      if (t_push) txq.push_back(i_core_data);
      if (r_pop) begin
        void'(rxq.pop_front());
        m_rx++;
      end
      if (r_push) begin
        rxq.push_back(i_net_data);
        if (i_net_data[3:0] != 4'(LOC)) m_err = 1'b1;
      end
    end
  end

  // Router grants against the enable it saw in the previous cycle.
  logic en_last = 1'b1;

  always @(negedge clk) begin
    en_last <= o_net_en;
    if (reset_n) begin
      chk("core_en", 32'(o_core_en), 32'(txq.size() < TXD));
      chk("net_val", 32'(o_net_val), 32'(txq.size() != 0));
      if (txq.size() != 0) chk("net_data", o_net_data, txq[0]);
      chk("net_en", 32'(o_net_en), 32'((RXD - rxq.size()) >= 2));
      chk("core_val", 32'(o_core_val), 32'(rxq.size() != 0));
      if (rxq.size() != 0) chk("core_data", o_core_data, rxq[0]);
      chk("tx_count", o_tx_count, m_tx);
      chk("rx_count", o_rx_count, m_rx);
      chk("dest_err", 32'(o_dest_err), 32'(m_err));
    end
  end

  int cv_p = 0, ne_p = 0, rv_p = 0, ce_p = 0, bad_p = 0;

  task automatic step(int n);
    logic [31:0] d;
    repeat (n) begin
      @(posedge clk);
      #1;
      i_core_val  = ($urandom_range(99) < cv_p);
      i_core_data = $urandom;
      i_net_en    = ($urandom_range(99) < ne_p);
      i_core_en   = ($urandom_range(99) < ce_p);
      i_net_val   = en_last && ($urandom_range(99) < rv_p);
      d = $urandom;
      if ($urandom_range(99) < bad_p)
        d[3:0] = 4'($urandom_range(15, 1));
      else
        d[3:0] = 4'(LOC);
      i_net_data = d;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_core_en", 32'(o_core_en), 32'd1);
    chk("rst_net_val", 32'(o_net_val), 32'd0);
    chk("rst_net_en", 32'(o_net_en), 32'd1);
    chk("rst_core_val", 32'(o_core_val), 32'd0);
    chk("rst_tx_count", o_tx_count, 32'd0);
    chk("rst_rx_count", o_rx_count, 32'd0);
    chk("rst_dest_err", 32'(o_dest_err), 32'd0);
    chk("rst_net_data", o_net_data, 32'd0);
    chk("rst_core_data", o_core_data, 32'd0);
    i_core_val = 1'b0;
    i_net_val  = 1'b0;
    i_net_en   = 1'b0;
    i_core_en  = 1'b0;
    cv_p = 0; ne_p = 0; rv_p = 0; ce_p = 0; bad_p = 0;
    @(negedge clk);
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    do_reset();

    // Single inject with dest=5
    step(1);
    @(posedge clk);
    #1;
    i_core_val = 1'b1;
    i_core_data = 32'hABCD_0005;
    i_net_en = 1'b1;
    @(posedge clk);
    #1;
    i_core_val = 1'b0;
    @(negedge clk);
    chk("inj_val", 32'(o_net_val), 32'd1);
    chk("inj_data", o_net_data, 32'hABCD_0005);
    @(negedge clk);
    chk("inj_count", o_tx_count, 32'd1);

    // TX backpressure
    do_reset();
    cv_p = 100; ne_p = 0;
    step(6);
    cv_p = 0;
    step(1);
    @(negedge clk);
    chk("bp_core_en", 32'(o_core_en), 32'd0);
    chk("bp_held", o_tx_count, 32'd0);
    ne_p = 100;
    step(6);
    @(negedge clk);
    chk("bp_drained", o_tx_count, 32'd4);

    // RX enable slack
    do_reset();
    rv_p = 100; ce_p = 0;
    step(6);
    rv_p = 0;
    step(1);
    @(negedge clk);
    chk("slack_en", 32'(o_net_en), 32'd0);
    chk("slack_val", 32'(o_core_val), 32'd1);
    ce_p = 100;
    step(6);
    @(negedge clk);
    chk("slack_rx", o_rx_count, 32'd4);

    // Misroute
    do_reset();
    ce_p = 100; rv_p = 100; bad_p = 100;
    step(1);
    bad_p = 0;
    step(6);
    rv_p = 0;
    step(2);
    @(negedge clk);
    chk("mis_sticky", 32'(o_dest_err), 32'd1);
    chk("mis_rx", o_rx_count, 32'd7);
    do_reset();
    @(negedge clk);
    chk("mis_clear", 32'(o_dest_err), 32'd0);

    // Full duplex streaming
    do_reset();
    cv_p = 100; ne_p = 100; rv_p = 100; ce_p = 100;
    step(100);
    cv_p = 0; rv_p = 0;
    step(4);
    @(negedge clk);
    chk("fd_tx", o_tx_count, 32'd100);
    chk("fd_rx", o_rx_count, 32'd100);

    // Random mix
    do_reset();
    for (int k = 0; k < 15; k++) begin
      cv_p  = $urandom_range(100);
      ne_p  = $urandom_range(100);
      rv_p  = $urandom_range(100);
      ce_p  = $urandom_range(100);
      bad_p = $urandom_range(3);
      step(200);
    end

    // Async reset with packets buffered both ways
    do_reset();
    cv_p = 100; rv_p = 100;
    step(3);
    cv_p = 0; rv_p = 0;
    step(1);
    @(negedge clk);
    chk("pre_rst_tx", 32'(o_net_val), 32'd1);
    chk("pre_rst_rx", 32'(o_core_val), 32'd1);
    do_reset();
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/enoc_network_interface.md
# enoc_network_interface

Endpoint network interface that attaches a processing core to the core port (port 0) of an ENoC router. It injects core packets into the router's core input channel and ejects packets from the router's core output channel back to the core, buffering each direction in its own FIFO and speaking the router's valid/enable handshake on both ends. Per-direction packet counters and a sticky misroute flag support network-level verification.

## Interface
- NODES, 16: total nodes in the network; packet dest width is log2(NODES).
- LOC, 0: this node's address; ejected packets must carry dest == LOC.
- TX_DEPTH, 4: injection FIFO depth in packets, power of 2, ≥2.
- RX_DEPTH, 4: ejection FIFO depth in packets, power of 2, ≥2.
- clk  input  1  single clock, all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- i_core_data  input  packet_t  packet from core for injection.
- i_core_val  input  1  core packet valid.
- o_core_en  output  1  NI can accept a core packet this cycle.
- o_net_data  output  packet_t  to router core input i_data[0].
- o_net_val  output  1  to router i_data_val[0].
- i_net_en  input  1  from router o_en[0]; router input FIFO not full.
- i_net_data  input  packet_t  from router o_data[0].
- i_net_val  input  1  from router o_data_val[0].
- o_net_en  output  1  to router i_en[0]; NI can accept ejected packets.
- o_core_data  output  packet_t  ejected packet to core.
- o_core_val  output  1  ejected packet valid.
- i_core_en  input  1  core accepts ejected packet this cycle.
- o_tx_count  output  32  packets injected into router.
- o_rx_count  output  32  packets delivered to core.
- o_dest_err  output  1  sticky: a packet with dest != LOC was ejected.

## Operation
- Transfer rule, every interface: a packet moves in a cycle where its val and the receiver's en are both high at the rising edge.
- Injection path: TX FIFO (TX_DEPTH entries, read/write pointers with wrap bit). o_core_en = TX not full. Push on i_core_val & o_core_en. o_net_val = TX not empty; o_net_data = TX head. Pop on o_net_val & i_net_en.
- Ejection path: RX FIFO (RX_DEPTH entries). Router output valid implies the grant is already committed, so the NI must never drop i_net_val. Push on i_net_val regardless of o_net_en. o_net_en = RX free entries ≥ 2 (one-cycle slack for a grant issued against the previous cycle's enable). o_core_val = RX not empty; o_core_data = RX head; pop on o_core_val & i_core_en.
- Overflow: i_net_val with RX full is a protocol violation; packet discarded, no pointer change, simulation assertion fires.
- Simultaneous push and pop in one FIFO same cycle: occupancy unchanged, both succeed (including full TX only if pop frees slot—TX push still gated by registered-state o_core_en, so no push at full).
- Counters: o_tx_count +1 per TX pop; o_rx_count +1 per RX pop; 32-bit, wrap 0xFFFF_FFFF→0.
- o_dest_err set on RX push with i_net_data.dest != LOC; cleared only by reset. Packet is still stored and delivered.
- Packet contents pass through unmodified; only dest is inspected.

## Timing
- Reset (async assert, sync release): pointers 0, both FIFOs empty, counters 0, o_dest_err 0. Outputs during reset: o_core_en 1, o_net_val 0, o_net_en 1, o_core_val 0, data outputs don't-care (drive '0).
- Injection latency: core push at edge N → o_net_val high in cycle after N (1 cycle minimum).
- Ejection latency: router push at edge N → o_core_val high in cycle after N.
- o_core_en, o_net_en, o_net_val, o_core_val are functions of registered occupancy only; no combinational path from any input to any output.
- Full throughput: one packet per cycle per direction sustained when partner en stays high.
- Reset mid-operation: all buffered packets lost, counters cleared immediately on reset_n fall.

## Test plan
- Reset then single inject: core sends dest=5 at cycle 2 with i_net_en=1 → o_net_val high cycle 3, o_net_data matches, o_tx_count=1 at cycle 4.
- TX backpressure: i_net_en=0, core streams 6 packets, TX_DEPTH=4 → o_core_en low after 4th accept, exactly 4 stored; release i_net_en → 4 packets out in order, one per cycle, o_tx_count=4.
- RX enable slack: i_core_en=0, router pushes back-to-back, RX_DEPTH=4 → o_net_en falls after 3rd push; 4th push (in-flight) still stored, no assertion, all 4 delivered in order when i_core_en=1.
- Misroute: LOC=0, eject packet with dest=3 → o_dest_err 1 next cycle and stays 1 through further good packets; packet still delivered; reset clears it.
- Full duplex streaming: both directions 100 packets, all en high → 1 packet/cycle each way, counters both 100, order preserved.
- Async reset mid-stream: assert reset_n low between edges with 3 packets in each FIFO → all valids 0 and counters 0 without a clock edge; after release, FIFOs empty.
